// File: rtl/div_clk_pkg.sv
// Shared types and helpers for the div_clk_bank clock divider bank.
// Optional phase alignment input is enabled with DIV_CLK_SYNC_EN.
package div_clk_pkg;

    // Widest divisor any instance may use; channels zero-extend into it.
    localparam int unsigned DIV_W_MAX = 32;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] act_div;
        logic [DIV_W_MAX-1:0] shadow;
        logic                 pending;
    } ch_cfg_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [DIV_W_MAX:0] half_ceil(
        input logic [DIV_W_MAX-1:0] d
    );
        return ({1'b0, d} + (DIV_W_MAX + 1)'(1)) >> 1;
    endfunction

endpackage

// File: rtl/div_clk_ch.sv
// One divider channel: counter, active/shadow divisor, registered outputs.
// With DIV_CLK_SYNC_EN a sync strobe realigns the channel to cnt 0.
module div_clk_ch
    import div_clk_pkg::*;
#(
    parameter int DIV_W     = 16,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
`ifdef DIV_CLK_SYNC_EN
    input  logic             sync,
`endif
    output logic             div_clk,
    output logic             tick,
    output logic             pending
);

    localparam logic [DIV_W_MAX-1:0] RST_X = DIV_W_MAX'(RESET_DIV);

    ch_cfg_t              cfg_q;
    logic [DIV_W-1:0]     cnt_q;
    logic [DIV_W_MAX-1:0] cnt_x;
    logic [DIV_W_MAX-1:0] wr_x;
    logic [DIV_W_MAX:0]   half;
    logic                 running;
    logic                 at_end;
    logic                 realign;
    logic                 apply;

    assign cnt_x   = DIV_W_MAX'(cnt_q);
    assign wr_x    = DIV_W_MAX'(wr_div);
    assign half    = half_ceil(cfg_q.act_div);
    assign running = sw && (cfg_q.act_div != '0);
    // Subtraction only matters while running, i.e. when act_div >= 1.
    assign at_end  = running &&
                     (cnt_x == cfg_q.act_div - DIV_W_MAX'(1));

`ifdef DIV_CLK_SYNC_EN
    assign realign = sync;
`else
    assign realign = 1'b0;
`endif

    assign apply = realign || !running || at_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            cfg_q.act_div <= RST_X;
            cfg_q.shadow  <= RST_X;
            cfg_q.pending <= 1'b0;
            div_clk       <= 1'b0;
            tick          <= 1'b0;
        end else begin
            tick    <= running && (cnt_q == '0);
            div_clk <= running && ({1'b0, cnt_x} < half);

            if (apply)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + DIV_W'(1);

            // A write landing on the apply edge bypasses the shadow.
            if (apply) begin
                cfg_q.act_div <= wr ? wr_x : cfg_q.shadow;
                cfg_q.shadow  <= wr ? wr_x : cfg_q.shadow;
                cfg_q.pending <= 1'b0;
            end else if (wr) begin
                cfg_q.shadow  <= wr_x;
                cfg_q.pending <= 1'b1;
            end
        end
    end

    assign pending = cfg_q.pending;

endmodule

// File: rtl/div_clk_bank.sv
// NUM_CH independent glitch-free programmable clock dividers.
// Define DIV_CLK_SYNC_EN to add the i_sync phase-alignment input.
module div_clk_bank
    import div_clk_pkg::*;
#(
    parameter  int NUM_CH    = 4,
    parameter  int DIV_W     = 16,
    parameter  int RESET_DIV = 2,
    localparam int CH_W      = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_sw,
    input  logic              i_cfg_valid,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [DIV_W-1:0]  i_cfg_div,
`ifdef DIV_CLK_SYNC_EN
    input  logic              i_sync,
`endif
    output logic [NUM_CH-1:0] o_div_clk,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_pending
);

    // Out-of-range channel numbers match no strobe and are dropped.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr;

        assign wr = i_cfg_valid && (i_cfg_ch == CH_W'(c));

        div_clk_ch #(
            .DIV_W     (DIV_W),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .sw      (i_sw[c]),
            .wr      (wr),
            .wr_div  (i_cfg_div),
`ifdef DIV_CLK_SYNC_EN
            .sync    (i_sync),
`endif
            .div_clk (o_div_clk[c]),
            .tick    (o_tick[c]),
            .pending (o_pending[c])
        );
    end

endmodule

// File: tb/tb_div_clk_bank.sv
// Directed self-checking bench for div_clk_bank (5 channels).
// Exercises the i_sync path too when DIV_CLK_SYNC_EN is defined.
module tb_div_clk_bank;

    localparam int NCH = 5;
    localparam int DW  = 16;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] i_sw;
    logic           i_cfg_valid;
    logic [2:0]     i_cfg_ch;
    logic [DW-1:0]  i_cfg_div;
`ifdef DIV_CLK_SYNC_EN
    logic           i_sync;
`endif
    logic [NCH-1:0] o_div_clk;
    logic [NCH-1:0] o_tick;
    logic [NCH-1:0] o_pending;

    int n_chk;
    int n_err;

    div_clk_bank #(
        .NUM_CH    (NCH),
        .DIV_W     (DW),
        .RESET_DIV (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sw        (i_sw),
        .i_cfg_valid (i_cfg_valid),
        .i_cfg_ch    (i_cfg_ch),
        .i_cfg_div   (i_cfg_div),
`ifdef DIV_CLK_SYNC_EN
        .i_sync      (i_sync),
`endif
        .o_div_clk   (o_div_clk),
        .o_tick      (o_tick),
        .o_pending   (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int ch, input int d);
        i_cfg_valid = 1'b1;
        i_cfg_ch    = 3'(ch);
        i_cfg_div   = DW'(d);
        step();
        i_cfg_valid = 1'b0;
    endtask

    task automatic cap(input int ch, input int n,
                       output logic [31:0] dv,
                       output logic [31:0] tk,
                       output logic [31:0] pd);
        dv = '0;
        tk = '0;
        pd = '0;
        repeat (n) begin
            step();
            dv = {dv[30:0], o_div_clk[ch]};
            tk = {tk[30:0], o_tick[ch]};
            pd = {pd[30:0], o_pending[ch]};
        end
    endtask

    logic [31:0] dv, tk, pd;

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst         = 1'b1;
        i_sw        = '1;
        i_cfg_valid = 1'b0;
        i_cfg_ch    = '0;
        i_cfg_div   = '0;
`ifdef DIV_CLK_SYNC_EN
        i_sync      = 1'b0;
`endif

        // Reset
        step();
        step();
        chk("rst_div", 32'(o_div_clk), 32'h0);
        chk("rst_tick", 32'(o_tick), 32'h0);
        chk("rst_pend", 32'(o_pending), 32'h0);
        rst = 1'b0;
        step();
        chk("first_div", 32'(o_div_clk), 32'h1f);
        chk("first_tick", 32'(o_tick), 32'h1f);
        step();
        chk("second_div", 32'(o_div_clk), 32'h0);
        cap(0, 6, dv, tk, pd);
        chk("d2_div", dv, 32'b101010);
        chk("d2_tick", tk, 32'b101010);

        // Odd divisor, D=1, D=0 on ch1
        i_sw[1] = 1'b0;
        step();
        cfg(1, 5);
        chk("d5_pend", 32'(o_pending[1]), 32'h0);
        i_sw[1] = 1'b1;
        cap(1, 10, dv, tk, pd);
        chk("d5_div", dv, 32'b1110011100);
        chk("d5_tick", tk, 32'b1000010000);
        i_sw[1] = 1'b0;
        cfg(1, 1);
        i_sw[1] = 1'b1;
        cap(1, 6, dv, tk, pd);
        chk("d1_div", dv, 32'b111111);
        chk("d1_tick", tk, 32'b111111);
        cfg(1, 0);
        cap(1, 6, dv, tk, pd);
        chk("d0_div", dv, 32'h0);
        chk("d0_tick", tk, 32'h0);
        chk("d0_pend", pd, 32'h0);

        // Glitch-free update on ch0: D=8 -> 3 written at cnt=2
        i_sw[0] = 1'b0;
        cfg(0, 8);
        i_sw[0] = 1'b1;
        step();
        step();
        cfg(0, 3);
        chk("upd_pend", 32'(o_pending[0]), 32'h1);
        cap(0, 12, dv, tk, pd);
        chk("upd_div", dv, 32'b100001101101);
        chk("upd_tick", tk, 32'b000001001001);
        chk("upd_pendw", pd, 32'b111100000000);

        // Boundary collision on ch2: D=4, write 6 at cnt=3
        i_sw[2] = 1'b0;
        cfg(2, 4);
        i_sw[2] = 1'b1;
        step();
        step();
        step();
        cfg(2, 6);
        chk("coll_pend", 32'(o_pending[2]), 32'h0);
        cap(2, 12, dv, tk, pd);
        chk("coll_div", dv, 32'b111000111000);
        chk("coll_tick", tk, 32'b100000100000);
        chk("coll_pendw", pd, 32'h0);
        cfg(2, 6);
        cfg(2, 10);
        cap(2, 16, dv, tk, pd);
        chk("last_tick", tk, 32'b0000100000000010);
        chk("last_pendw", pd, 32'b1110000000000000);

        // Disable / re-enable ch3
        i_sw[3] = 1'b0;
        step();
        chk("dis_out", 32'({o_div_clk[3], o_tick[3]}), 32'h0);
        i_sw[3] = 1'b1;
        step();
        chk("reen_out", 32'({o_div_clk[3], o_tick[3]}), 32'h3);

        // Out-of-range channel write
        chk("oor_pre", 32'(o_pending), 32'h0);
        cfg(5, 7);
        chk("oor_pend", 32'(o_pending), 32'h0);
        step();
        chk("oor_pend2", 32'(o_pending), 32'h0);

`ifdef DIV_CLK_SYNC_EN
        // Phase alignment: ch0 D=4, ch1 D=6
        cfg(0, 4);
        cfg(1, 6);
        step();
        step();
        step();
        i_sync = 1'b1;
        step();
        i_sync = 1'b0;
        step();
        chk("sync_tick", 32'(o_tick[1:0]), 32'h3);
        repeat (11) step();
        step();
        chk("sync_tick12", 32'(o_tick[1:0]), 32'h3);
`endif

        // Reset mid-operation discards a pending write
        cfg(0, 9);
        chk("mid_pend", 32'(o_pending[0]), 32'h1);
        rst = 1'b1;
        step();
        chk("mid_rst_pend", 32'(o_pending), 32'h0);
        chk("mid_rst_div", 32'(o_div_clk), 32'h0);
        rst = 1'b0;
        cap(0, 4, dv, tk, pd);
        chk("mid_rst_d2", tk, 32'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
